// File: rtl/sha3_pkg.sv
// Shared types and constants for the variable-rate SHA3 padder.
package sha3_pkg;

  localparam int LANE_W = 64;

  localparam logic [7:0] PAD_SHA3   = 8'h06;
  localparam logic [7:0] PAD_KECCAK = 8'h01;
  localparam logic [7:0] PAD_END    = 8'h80;

  typedef enum logic [1:0] {
    SHA3_224 = 2'b00,
    SHA3_256 = 2'b01,
    SHA3_384 = 2'b10,
    SHA3_512 = 2'b11
  } mode_t;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_ABSORB = 2'd1;
  localparam state_t ST_FULL   = 2'd2;
  localparam state_t ST_FINAL  = 2'd3;

  // Rate in 64-bit lanes: (1600 - 2*digest_bits) / 64.
  function automatic logic [4:0] rate_lanes(input mode_t m);
    case (m)
      SHA3_224: rate_lanes = 5'd18;
      SHA3_256: rate_lanes = 5'd17;
      SHA3_384: rate_lanes = 5'd13;
      default:  rate_lanes = 5'd9;
    endcase
  endfunction

endpackage

// File: rtl/sha3_pad_word.sv
// Combinational padding of the final message word: keeps n data bytes, inserts
// the domain byte at position n and ORs 0x80 into the last byte of the rate.
module sha3_pad_word
  import sha3_pkg::*;
(
  input  logic [LANE_W-1:0] i_word,
  input  logic [2:0]        i_byte_num,
  input  logic [7:0]        i_dom,
  input  logic              i_final_lane,
  output logic [LANE_W-1:0] o_lane
);

  always_comb begin
    // NOTE: default every output first so no path through the loop infers a latch.
    o_lane = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < int'(i_byte_num))
        o_lane[63-8*b -: 8] = i_word[63-8*b -: 8];
      else if (b == int'(i_byte_num))
        o_lane[63-8*b -: 8] = i_dom;
    end
    if (i_final_lane)
      o_lane[7:0] = o_lane[7:0] | PAD_END;
  end

endmodule

// File: rtl/sha3_padder_var.sv
// Variable-rate SHA3 padder front end (224/256/384/512 selected per message).
// Define SHA3_KECCAK_LEGACY_EN to add iLegacy, selecting original Keccak 0x01 padding.
module sha3_padder_var
  import sha3_pkg::*;
#(
  parameter int LANE_W    = 64,
  parameter int MAX_LANES = 18
) (
  input  logic                        iClk,
  input  logic                        iRst_n,
  input  logic [1:0]                  iMode,
`ifdef SHA3_KECCAK_LEGACY_EN
  input  logic                        iLegacy,
`endif
  input  logic [LANE_W-1:0]           iData,
  input  logic                        iReady,
  input  logic                        iLast,
  input  logic [2:0]                  iByte_num,
  output logic                        oBuffer_full,
  output logic [MAX_LANES*LANE_W-1:0] oData,
  output logic                        oReady,
  output logic                        oLast_block,
  input  logic                        iF_ack
);

  state_t            r_state;
  mode_t             r_mode;
  logic [4:0]        r_cnt;
  logic [LANE_W-1:0] r_buf [MAX_LANES];

  logic              w_busy;
  logic              w_idle;
  logic              w_accept;
  mode_t             w_mode;
  logic [4:0]        w_last_idx;
  logic              w_final_lane;
  logic [7:0]        w_dom;
  logic [LANE_W-1:0] w_pad_lane;

  assign w_busy       = (r_state == ST_FULL) || (r_state == ST_FINAL);
  assign w_idle       = (r_state == ST_IDLE);
  assign w_accept     = iReady & ~w_busy;
  // The mode is taken live on the first word, then held for the rest of the message.
  assign w_mode       = w_idle ? mode_t'(iMode) : r_mode;
  assign w_last_idx   = rate_lanes(w_mode) - 5'd1;
  assign w_final_lane = (r_cnt == w_last_idx);

  assign oReady       = w_busy;
  assign oBuffer_full = w_busy;
  assign oLast_block  = (r_state == ST_FINAL);

`ifdef SHA3_KECCAK_LEGACY_EN
  logic r_legacy;
  logic w_legacy;
  assign w_legacy = w_idle ? iLegacy : r_legacy;
  assign w_dom    = w_legacy ? PAD_KECCAK : PAD_SHA3;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n)
      r_legacy <= 1'b0;
    else if (w_accept && w_idle)
      r_legacy <= iLegacy;
  end
`else
  assign w_dom = PAD_SHA3;
`endif

  sha3_pad_word u_pad_word (
    .i_word       (iData),
    .i_byte_num   (iByte_num),
    .i_dom        (w_dom),
    .i_final_lane (w_final_lane),
    .o_lane       (w_pad_lane)
  );

  // NOTE: state updates use non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state <= ST_IDLE;
      r_mode  <= SHA3_224;
      r_cnt   <= '0;
      // NOTE: the rate buffer is reset because oData must read zero out of reset.
      for (int i = 0; i < MAX_LANES; i++)
        r_buf[i] <= '0;
    end else if (!w_busy) begin
      if (w_accept) begin
        if (w_idle)
          r_mode <= w_mode;
        if (iLast) begin
          r_buf[r_cnt] <= w_pad_lane;
          // Lanes above cnt are already zero, only the rate's last byte needs 0x80.
          if (!w_final_lane)
            r_buf[w_last_idx] <= {{(LANE_W-8){1'b0}}, PAD_END};
          r_state <= ST_FINAL;
        end else begin
          r_buf[r_cnt] <= iData;
          if (w_final_lane) begin
            r_state <= ST_FULL;
          end else begin
            r_cnt   <= r_cnt + 5'd1;
            r_state <= ST_ABSORB;
          end
        end
      end
    end else if (iF_ack) begin
      for (int i = 0; i < MAX_LANES; i++)
        r_buf[i] <= '0;
      r_cnt   <= '0;
      r_state <= (r_state == ST_FULL) ? ST_ABSORB : ST_IDLE;
    end
  end

  for (genvar g = 0; g < MAX_LANES; g++) begin : g_out
    assign oData[(MAX_LANES-g)*LANE_W-1 -: LANE_W] = r_buf[g];
  end

endmodule
